// File: rtl/tpuv2_seq.sv
// tpuv2_seq: MMIO-driven sequencer for a DIM x DIM systolic matmul array.
// A command optionally clears the accumulators, then streams K operands through the skewed array.
module tpuv2_seq #(
    parameter int               DIM       = 8,
    parameter int               MAX_K     = 64,
    parameter int               ADDRW     = 16,
    parameter int               DATAW     = 64,
    parameter logic [ADDRW-1:0] CMD_ADDR  = 'h400,
    parameter logic [ADDRW-1:0] STAT_ADDR = 'h408
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ADDRW-1:0] addr,
    input  logic             r_w,
    input  logic [DATAW-1:0] dataIn,
    output logic [DATAW-1:0] dataOut,
    output logic             rdValid,
    output logic             mem_en,
    output logic             sys_en,
    output logic             sys_clr,
    output logic             busy,
    output logic             irq,
    output logic [1:0]       state_dbg
);
    localparam int KW = $clog2(MAX_K);
    localparam int CW = $clog2(MAX_K + 2*DIM - 2);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;

    // Pipeline drain beyond the K operand beats: the skew fills and empties across 2*DIM-2 cycles.
    localparam logic [CW-1:0] SKEW = CW'(2*DIM - 2);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [KW-1:0]    k_m1;
    logic             done;
    logic             err;
    logic             cmd_hit;
    logic             stat_rd;
    logic             stat_wr;
    logic             start;
    logic             cmd_ignored;
    logic             last;
    logic [DATAW-1:0] stat_word;
    logic             unused_bits;

    assign cmd_hit     = r_w && (addr == CMD_ADDR);
    assign stat_rd     = !r_w && (addr == STAT_ADDR);
    assign stat_wr     = r_w && (addr == STAT_ADDR);
    assign start       = cmd_hit && (state == IDLE);
    assign cmd_ignored = cmd_hit && (state != IDLE);
    assign last        = (state == RUN) && (cnt == CW'(k_m1) + SKEW);

    assign busy      = (state != IDLE);
    assign sys_en    = (state == RUN);
    assign sys_clr   = (state == CLEAR);
    assign mem_en    = (state == RUN) && (cnt <= CW'(k_m1));
    assign state_dbg = state;

    assign unused_bits = ^{dataIn[DATAW-1:8+KW], dataIn[7:3], dataIn[1]};

    always_comb begin
        stat_word           = '0;
        stat_word[8 +: KW]  = k_m1;
        stat_word[2]        = err;
        stat_word[1]        = done;
        stat_word[0]        = busy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            k_m1  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= dataIn[0] ? RUN : CLEAR;
                        k_m1  <= dataIn[8 +: KW];
                        cnt   <= '0;
                    end
                end
                CLEAR: state <= RUN;
                RUN: begin
                    if (last) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completion wins over a same-edge read clear; an ignored command wins over an err clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            err     <= 1'b0;
            irq     <= 1'b0;
            rdValid <= 1'b0;
            dataOut <= '0;
        end else begin
            irq     <= last;
            rdValid <= stat_rd;
            if (stat_rd)
                dataOut <= stat_word;
            if (last)
                done <= 1'b1;
            else if (start || stat_rd)
                done <= 1'b0;
            if (cmd_ignored)
                err <= 1'b1;
            else if (stat_wr && dataIn[2])
                err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_tpuv2_seq.sv
// tb_tpuv2_seq: randomized scenario bench for tpuv2_seq against a cycle-count reference model.
module tb_tpuv2_seq;
    localparam int DIM   = 8;
    localparam int MAX_K = 64;
    localparam int ADDRW = 16;
    localparam int DATAW = 64;
    localparam logic [ADDRW-1:0] CMD_A   = 'h400;
    localparam logic [ADDRW-1:0] STAT_A  = 'h408;
    localparam logic [ADDRW-1:0] OTHER_A = 'h410;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [ADDRW-1:0] addr = '0;
    logic             r_w = 1'b0;
    logic [DATAW-1:0] dataIn = '0;
    logic [DATAW-1:0] dataOut;
    logic             rdValid;
    logic             mem_en;
    logic             sys_en;
    logic             sys_clr;
    logic             busy;
    logic             irq;
    logic [1:0]       state_dbg;

    int errors = 0;
    int checks = 0;

    // Reference model of the architectural status registers.
    int m_done = 0;
    int m_err  = 0;
    int m_kf   = 0;

    tpuv2_seq #(
        .DIM(DIM), .MAX_K(MAX_K), .ADDRW(ADDRW), .DATAW(DATAW),
        .CMD_ADDR(CMD_A), .STAT_ADDR(STAT_A)
    ) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .r_w(r_w), .dataIn(dataIn),
        .dataOut(dataOut), .rdValid(rdValid), .mem_en(mem_en), .sys_en(sys_en),
        .sys_clr(sys_clr), .busy(busy), .irq(irq), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [DATAW-1:0] stat_word(input int b);
        logic [DATAW-1:0] w;
        w = (DATAW'(m_kf) << 8) | (DATAW'(m_err) << 2) | (DATAW'(m_done) << 1) | DATAW'(b);
        return w;
    endfunction

    task automatic bus_idle();
        addr = '0; r_w = 1'b0; dataIn = '0;
    endtask

    task automatic drive_cmd(input int acc, input int kf);
        addr = CMD_A; r_w = 1'b1; dataIn = (DATAW'(kf) << 8) | DATAW'(acc);
    endtask

    task automatic drive_read();
        addr = STAT_A; r_w = 1'b0; dataIn = '0;
    endtask

    // Issue a status read and check the one-cycle snapshot and the hold afterwards.
    task automatic read_stat(input string name, input logic [DATAW-1:0] exp);
        drive_read();
        @(posedge clk);
        m_done = 0;
        @(negedge clk);
        bus_idle();
        checks++;
        if (rdValid !== 1'b1 || dataOut !== exp) begin
            errors++;
            $display("FAIL %s: rdValid=%0b dataOut=%0h, required rdValid=1 dataOut=%0h", name, rdValid, dataOut, exp);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rdValid !== 1'b0 || dataOut !== exp) begin
            errors++;
            $display("FAIL %s_hold: rdValid=%0b dataOut=%0h, required rdValid=0 dataOut=%0h", name, rdValid, dataOut, exp);
        end
    endtask

    task automatic write_stat(input logic [DATAW-1:0] v);
        addr = STAT_A; r_w = 1'b1; dataIn = v;
        @(posedge clk);
        if (v[2]) m_err = 0;
        @(negedge clk);
        bus_idle();
        checks++;
        if (rdValid !== 1'b0) begin
            errors++;
            $display("FAIL stat_write_rdvalid: rdValid=%0b, required 0", rdValid);
        end
    endtask

    // Run one command; inj_i/rd_i are cycle indices (cycle T+1+i) at which to drive an extra
    // command write or a status read (-1 for none).
    task automatic run_cmd(input string name, input int acc, input int kf, input int inj_i, input int rd_i);
        int clr;
        int k;
        int fin;
        int rd_edge;
        int inj_edge;
        logic [DATAW-1:0] snap;
        logic [4:0] got;
        logic [4:0] exp;
        clr = (acc != 0) ? 0 : 1;
        k = kf + 1;
        fin = clr + k + 2*DIM - 2;
        rd_edge = -1;
        inj_edge = -1;
        snap = '0;
        drive_cmd(acc, kf);
        @(posedge clk);
        m_done = 0;
        m_kf = kf;
        @(negedge clk);
        bus_idle();
        for (int i = 0; i <= fin + 1; i++) begin
            if (i > 0) begin
                @(posedge clk);
                if (rd_edge == i) m_done = 0;
                if (i == fin) m_done = 1;
                if (inj_edge == i) m_err = 1;
                @(negedge clk);
                bus_idle();
            end
            exp[4] = (i < fin);
            exp[3] = (i < clr);
            exp[2] = (i >= clr) && (i < fin);
            exp[1] = (i >= clr) && (i < fin) && ((i - clr) < k);
            exp[0] = (i == fin);
            got = {busy, sys_clr, sys_en, mem_en, irq};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s_cycle%0d: {busy,clr,en,mem,irq}=%b, required %b", name, i, got, exp);
            end
            if (rd_edge == i) begin
                checks++;
                if (rdValid !== 1'b1 || dataOut !== snap) begin
                    errors++;
                    $display("FAIL %s_snapshot: rdValid=%0b dataOut=%0h, required rdValid=1 dataOut=%0h", name, rdValid, dataOut, snap);
                end
            end
            if (i == inj_i) begin
                drive_cmd(int'($urandom_range(0, 1)), int'($urandom_range(0, MAX_K-1)));
                inj_edge = i + 1;
            end
            if (i == rd_i) begin
                snap = stat_word((i < fin) ? 1 : 0);
                drive_read();
                rd_edge = i + 1;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, sys_clr, sys_en, mem_en, irq, rdValid} !== 6'b0 || dataOut !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%0b clr=%0b en=%0b mem=%0b irq=%0b rdValid=%0b dataOut=%0h, required all 0",
                     busy, sys_clr, sys_en, mem_en, irq, rdValid, dataOut);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_stat("reset_status", stat_word(0));
    endtask

    task automatic test_clear_run();
        run_cmd("clear_run", 0, 7, -1, -1);
        read_stat("clear_run_read1", 64'h702);
        read_stat("clear_run_read2", 64'h700);
    endtask

    task automatic test_accumulate();
        run_cmd("accumulate", 1, 7, -1, -1);
        read_stat("accumulate_read1", 64'h702);
        read_stat("accumulate_read2", 64'h700);
    endtask

    task automatic test_busy_write();
        run_cmd("busy_write", 0, 9, 1 + 5, -1);
        read_stat("busy_write_err", stat_word(0));
        write_stat(64'h4);
        read_stat("busy_write_errclr", stat_word(0));
    endtask

    task automatic test_boundaries();
        run_cmd("k_min", int'($urandom_range(0, 1)), 0, -1, -1);
        read_stat("k_min_status", stat_word(0));
        run_cmd("k_max", int'($urandom_range(0, 1)), MAX_K - 1, -1, -1);
        read_stat("k_max_status", stat_word(0));
    endtask

    task automatic test_read_at_completion();
        // acc=1, K=5: completion edge begins cycle index 19, so read is driven in cycle 18.
        run_cmd("read_at_done", 1, 4, -1, 18);
        read_stat("read_after_done", stat_word(0));
    endtask

    task automatic test_other_addr();
        addr = OTHER_A; r_w = 1'b1; dataIn = 64'h0705;
        @(posedge clk);
        @(negedge clk);
        addr = OTHER_A; r_w = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rdValid !== 1'b0) begin
            errors++;
            $display("FAIL other_addr: busy=%0b rdValid=%0b, required busy=0 rdValid=0", busy, rdValid);
        end
        bus_idle();
        read_stat("other_addr_status", stat_word(0));
    endtask

    task automatic test_async_reset();
        int seen_irq;
        seen_irq = 0;
        drive_cmd(0, 20);
        @(posedge clk);
        @(negedge clk);
        bus_idle();
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        m_done = 0; m_err = 0; m_kf = 0;
        checks++;
        if ({busy, sys_clr, sys_en, mem_en, irq, rdValid} !== 6'b0 || dataOut !== '0) begin
            errors++;
            $display("FAIL async_reset: busy=%0b clr=%0b en=%0b mem=%0b irq=%0b rdValid=%0b dataOut=%0h, required all 0",
                     busy, sys_clr, sys_en, mem_en, irq, rdValid, dataOut);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (irq !== 1'b0 || busy !== 1'b0) seen_irq++;
        end
        checks++;
        if (seen_irq != 0) begin
            errors++;
            $display("FAIL async_reset_quiet: active cycles=%0d, required 0", seen_irq);
        end
        read_stat("async_reset_status", stat_word(0));
        run_cmd("after_reset", 0, 7, -1, -1);
        read_stat("after_reset_status", 64'h702);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            run_cmd("random", int'($urandom_range(0, 1)), int'($urandom_range(0, MAX_K-1)), -1,
                    ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 12)) : -1);
            read_stat("random_status", stat_word(0));
        end
    endtask

    initial begin
        bus_idle();
        #1;
        test_reset();
        test_clear_run();
        test_accumulate();
        test_busy_write();
        test_boundaries();
        test_read_at_completion();
        test_other_addr();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
